decode_stage: RTL

//  ID stage, directly downstream of the fetch register and immediate extensor in cpu.
//  - Reads fetched_instr/fetched_addr/immediate and splits the RV32I fields.
//  - Reads rs1/rs2 from an internal 32x32 register file; writeback writes that file.
//  - Detects load-use hazards and registers a decoded bundle for the execute stage.

---
 rtl/decode_pkg.sv | 33 +++
 rtl/regfile.sv | 52 +++++
 rtl/decode_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions for the ID stage.
// Contents:
//   - RV32I base opcodes (bits [6:0] of the instruction).
//   - cls_e: the 4-bit instruction class passed to the execute stage.
//   - NOP_INSTR: the bubble instruction (addi x0,x0,0).
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_LUI    = 4'd1,
        CLS_AUIPC  = 4'd2,
        CLS_JAL    = 4'd3,
        CLS_JALR   = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_LOAD   = 4'd6,
        CLS_STORE  = 4'd7,
        CLS_OPIMM  = 4'd8,
        CLS_OP     = 4'd9
    } cls_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/regfile.sv
// 32 x DWIDTH integer register file.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset (clears all entries)
//   ra1, ra2      read addresses; rd1, rd2 combinational read data
//   we, wa, wd    synchronous write port; writes to x0 are dropped
// Reads of x0 return 0. A read of the register being written in the same
// cycle returns the write data (write-through bypass).
module regfile #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [DWIDTH-1:0] rd1,
    output logic [DWIDTH-1:0] rd2,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DWIDTH-1:0] wd
);

    logic [DWIDTH-1:0] regs [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == 5'd0) begin
            rd1 = '0;
        end else if (we && (wa == ra1)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == 5'd0) begin
            rd2 = '0;
        end else if (we && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction decode (ID) stage.
// Splits the fetched instruction into fields, classifies it by opcode, reads
// rs1/rs2 from the internal register file, detects load-use hazards and
// registers the decoded bundle into the ID/EX register.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_instr/in_addr/in_imm   fetch register and extensor immediate
//   stall                        hold ID/EX contents
//   flush                        squash ID/EX (highest priority)
//   ex_is_load, ex_rd            instruction currently in EX
//   wb_we, wb_rd, wb_data        register file write port
//   hazard                       combinational load-use hazard (fetch must hold)
//   out_*                        registered ID/EX bundle
module decode_stage
    import decode_pkg::*;
#(
    parameter int                AWIDTH = 15,
    parameter int                DWIDTH = 32,
    parameter logic [DWIDTH-1:0] NOP    = DWIDTH'(NOP_INSTR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_instr,
    input  logic [AWIDTH-1:0] in_addr,
    input  logic [DWIDTH-1:0] in_imm,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_rd,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [DWIDTH-1:0] wb_data,
    output logic              hazard,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_instr,
    output logic [AWIDTH-1:0] out_addr,
    output logic [DWIDTH-1:0] out_imm,
    output logic [DWIDTH-1:0] out_rs1_val,
    output logic [DWIDTH-1:0] out_rs2_val,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output cls_e              out_class,
    output logic              out_illegal
);

    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [6:0]        funct7;
    cls_e              cls;
    logic              illegal;
    logic              uses_rs1;
    logic              uses_rs2;
    logic [DWIDTH-1:0] rs1_val;
    logic [DWIDTH-1:0] rs2_val;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    always_comb begin
        cls     = CLS_NONE;
        illegal = 1'b0;
        unique case (opcode)
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_OPIMM:  cls = CLS_OPIMM;
            OPC_OP:     cls = CLS_OP;
            default:    illegal = 1'b1;
        endcase
    end

    // Unknown opcodes are conservatively treated as reading rs1.
    assign uses_rs1 = !((cls == CLS_LUI) || (cls == CLS_AUIPC) || (cls == CLS_JAL));
    assign uses_rs2 = (cls == CLS_BRANCH) || (cls == CLS_STORE) || (cls == CLS_OP);

    assign hazard = in_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

    regfile #(
        .DWIDTH(DWIDTH)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rs1_val),
        .rd2 (rs2_val),
        .we  (wb_we),
        .wa  (wb_rd),
        .wd  (wb_data)
    );

    // Flush beats stall; stall beats the hazard bubble. A bubble clears the
    // whole bundle to its reset image so EX never sees stale fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || (!stall && hazard)) begin
            out_valid   <= 1'b0;
            out_instr   <= NOP;
            out_addr    <= '0;
            out_imm     <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_class   <= CLS_NONE;
            out_illegal <= 1'b0;
        end else if (!stall) begin
            out_valid   <= in_valid;
            out_instr   <= in_instr;
            out_addr    <= in_addr;
            out_imm     <= in_imm;
            out_rs1_val <= rs1_val;
            out_rs2_val <= rs2_val;
            out_rd      <= rd;
            out_rs1     <= rs1;
            out_rs2     <= rs2;
            out_funct3  <= funct3;
            out_funct7  <= funct7;
            out_class   <= cls;
            out_illegal <= illegal;
        end
    end

endmodule
